int_controller: RTL and testbench
=================================

INT_CONTROLLER -- requirements
Module: int_controller

Interface
REQ-001 Parameter NUM_SRC, default 4: number of external interrupt sources, range 1..16.
REQ-002 Parameter PC_W, default 11: program-counter width.
REQ-003 Parameter TIME_W, default 16: timer width.
REQ-004 Parameter CODE_W, default 32: width of cause code written to register bank.
REQ-005 Parameter VECTOR, default 0: PC_W-bit handler address.
REQ-006 clk  in  1  CPU clock; all state updates on posedge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 halt  in  1  halt instruction executing this cycle.
REQ-009 set  in  1  timer load strobe (setClock instruction).
REQ-010 int_time  in  TIME_W  timer load value (instruction immediate).
REQ-011 auto_reload  in  1  sampled with set; 1 = periodic timer.
REQ-012 src_req  in  NUM_SRC  external requests, rising-edge sensitive.
REQ-013 mask_we  in  1  mask register write strobe.
REQ-014 mask_in  in  NUM_SRC+2  enable bits: [0] timer, [1] halt, [i+2] src_req[i].
REQ-015 pc  in  PC_W  address of current instruction.
REQ-016 next_pc  in  PC_W  PC value the CPU would load next.
REQ-017 get_int  in  1  handler reads cause (getInterruption); clears int_code.
REQ-018 int_ret  in  1  handler return; ends service.
REQ-019 int_take  out  1  one-cycle pulse: CPU loads VECTOR into PC instead of next_pc.
REQ-020 int_vector  out  PC_W  constant VECTOR.
REQ-021 int_code  out  CODE_W  cause: 0 none, 1 timer, 2 halt, i+3 src_req[i].
REQ-022 saved_pc  out  PC_W  return address captured on take.
REQ-023 pending  out  NUM_SRC+2  latched unmasked-or-masked pending bits, same layout as mask_in.
REQ-024 busy  out  1  handler in service.

Function
REQ-025 States IDLE, TAKE, SERVICE; IDLE->TAKE when any (pending & mask) bit set; TAKE->SERVICE unconditionally after one cycle; SERVICE->IDLE on int_ret.
REQ-026 int_take high exactly in TAKE cycle; int_code and saved_pc update on edge entering TAKE.
REQ-027 Priority: halt > timer > src_req[0] > ... > src_req[NUM_SRC-1]; the taken bit clears from pending on entry to TAKE, others remain.
REQ-028 saved_pc = pc for halt (re-execution not required, handler decides), next_pc for timer and external sources.
REQ-029 halt sets pending[1] each cycle asserted; src_req rising edge (registered previous value) sets pending[i+2].
REQ-030 Timer: set loads counter = int_time and arms; armed counter decrements by 1 per clk; on transition 1->0 sets pending[0]; auto_reload=1 reloads int_time copy and stays armed, else disarms.
REQ-031 set with int_time = 0 disarms timer, no interrupt.
REQ-032 set in same cycle as expiry: load wins, expiry discarded.
REQ-033 Timer counts in all states; expiry during SERVICE only latches pending.
REQ-034 No nesting: requests arriving in TAKE/SERVICE latch into pending, taken after return to IDLE (earliest one cycle after int_ret).
REQ-035 get_int clears int_code to 0 next edge; saved_pc holds until next take.
REQ-036 Masked pending bits stay latched; unmasking later triggers take.
REQ-037 int_ret in IDLE or TAKE ignored; get_int and new edge same cycle: both act.

Reset
REQ-038 rst_n low asynchronously forces: state IDLE, int_take 0, int_code 0, saved_pc 0, pending 0, busy 0, timer disarmed/counter 0, mask all ones, src edge registers 0.
REQ-039 Reset mid-SERVICE or mid-countdown abandons all state; no interrupt after release until new request.

Structure
REQ-040 Shared package holds cause-code constants (CODE_NONE, CODE_TIMER, CODE_HALT, CODE_EXT_BASE) and state encoding.
REQ-041 Sub-module int_timer (load, auto-reload, expiry pulse) instantiated once.

Verification
REQ-042 set int_time=5, auto_reload=0 -> int_take on 6th edge after set, int_code=1, saved_pc=next_pc; no further take.
REQ-043 auto_reload=1, int_time=3, int_ret each take -> int_take every 3 cycles while serviced promptly.
REQ-044 halt and src_req[0] rise same cycle -> code 2 taken first; after int_ret code 3 taken.
REQ-045 mask_in bit 2 clear, src_req[0] rises -> no take, pending[2]=1; set bit -> take next cycle with code 3.
REQ-046 rst_n low during SERVICE with timer armed -> all outputs 0 immediately, no take after release.

Source files
------------

// File: rtl/int_controller_pkg.sv
// Shared definitions for the interrupt controller: cause codes,
// pending/mask bit positions and the controller state encoding.
package int_controller_pkg;

  // Cause codes reported to the handler through int_code
  localparam int CODE_NONE     = 0;
  localparam int CODE_TIMER    = 1;
  localparam int CODE_HALT     = 2;
  localparam int CODE_EXT_BASE = 3;

  // Bit positions inside pending/mask vectors
  localparam int PEND_TIMER    = 0;
  localparam int PEND_HALT     = 1;
  localparam int PEND_EXT_BASE = 2;

  // Controller sequencing states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TAKE    = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/int_controller_timer.sv
// Programmable countdown timer: load, optional periodic reload and a
// single-cycle expiry indication on the 1->0 transition.
module int_timer #(
  parameter int TIME_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [TIME_W-1:0] i_time,
  input  logic              i_auto,
  output logic              o_expire
);

  logic [TIME_W-1:0] r_count;
  logic [TIME_W-1:0] r_reload;
  logic              r_auto;
  logic              r_armed;

  // A load in the same cycle as the final count suppresses the expiry
  assign o_expire = r_armed && (r_count == TIME_W'(1)) && !i_load;

  // Counter: load has priority over counting; zero load value disarms
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_reload <= '0;
      r_auto   <= 1'b0;
      r_armed  <= 1'b0;
    end else if (i_load) begin
      r_count  <= i_time;
      r_reload <= i_time;
      r_auto   <= i_auto;
      r_armed  <= (i_time != '0);
    end else if (r_armed) begin
      if (r_count == TIME_W'(1)) begin
        if (r_auto) begin
          r_count <= r_reload;
        end else begin
          r_count <= '0;
          r_armed <= 1'b0;
        end
      end else begin
        r_count <= r_count - TIME_W'(1);
      end
    end
  end

endmodule

// File: rtl/int_controller.sv
// Interrupt controller: latches timer, halt and external edge requests,
// arbitrates by fixed priority and sequences a single non-nested handler.
module int_controller
  import int_controller_pkg::*;
#(
  parameter int              NUM_SRC = 4,
  parameter int              PC_W    = 11,
  parameter int              TIME_W  = 16,
  parameter int              CODE_W  = 32,
  parameter logic [PC_W-1:0] VECTOR  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 halt,
  input  logic                 set,
  input  logic [TIME_W-1:0]    int_time,
  input  logic                 auto_reload,
  input  logic [NUM_SRC-1:0]   src_req,
  input  logic                 mask_we,
  input  logic [NUM_SRC+1:0]   mask_in,
  input  logic [PC_W-1:0]      pc,
  input  logic [PC_W-1:0]      next_pc,
  input  logic                 get_int,
  input  logic                 int_ret,
  output logic                 int_take,
  output logic [PC_W-1:0]      int_vector,
  output logic [CODE_W-1:0]    int_code,
  output logic [PC_W-1:0]      saved_pc,
  output logic [NUM_SRC+1:0]   pending,
  output logic                 busy
);

  localparam int PW = NUM_SRC + 2;

  state_t              r_state;
  logic                r_take;
  logic                r_busy;
  logic [CODE_W-1:0]   r_code;
  logic [PC_W-1:0]     r_saved_pc;
  logic [PW-1:0]       r_pending;
  logic [PW-1:0]       r_mask;
  logic [NUM_SRC-1:0]  r_src_prev;

  logic                w_expire;
  logic [NUM_SRC-1:0]  w_rise;
  logic [PW-1:0]       w_set_bits;
  logic [PW-1:0]       w_active;
  logic [PW-1:0]       w_sel;
  logic [PW-1:0]       w_clr;
  logic [CODE_W-1:0]   w_code;
  logic                w_sel_halt;
  logic                w_take_now;

  int_timer #(
    .TIME_W (TIME_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (set),
    .i_time   (int_time),
    .i_auto   (auto_reload),
    .o_expire (w_expire)
  );

  assign w_rise     = src_req & ~r_src_prev;
  assign w_set_bits = {w_rise, halt, w_expire};
  assign w_active   = r_pending & r_mask;
  assign w_take_now = (r_state == ST_IDLE) && (|w_active);
  assign w_clr      = w_take_now ? w_sel : '0;
  assign w_sel_halt = w_active[PEND_HALT];

  // Fixed-priority select: halt, then timer, then lowest external index
  always_comb begin
    w_sel  = '0;
    w_code = CODE_W'(CODE_NONE);
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_active[PEND_EXT_BASE + i]) begin
        w_sel                    = '0;
        w_sel[PEND_EXT_BASE + i] = 1'b1;
        w_code                   = CODE_W'(CODE_EXT_BASE + i);
      end
    end
    if (w_active[PEND_TIMER]) begin
      w_sel             = '0;
      w_sel[PEND_TIMER] = 1'b1;
      w_code            = CODE_W'(CODE_TIMER);
    end
    if (w_active[PEND_HALT]) begin
      w_sel            = '0;
      w_sel[PEND_HALT] = 1'b1;
      w_code           = CODE_W'(CODE_HALT);
    end
  end

  // Previous external request levels for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_prev <= '0;
    end else begin
      r_src_prev <= src_req;
    end
  end

  // Mask register; every cause enabled out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= '1;
    end else if (mask_we) begin
      r_mask <= mask_in;
    end
  end

  // Pending latch: taken bit is cleared, new requests are always captured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set_bits;
    end
  end

  // Handler sequencing with registered take pulse, busy, cause and return PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_take     <= 1'b0;
      r_busy     <= 1'b0;
      r_code     <= '0;
      r_saved_pc <= '0;
    end else begin
      r_take <= 1'b0;
      if (get_int) begin
        r_code <= '0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_take_now) begin
            r_state    <= ST_TAKE;
            r_take     <= 1'b1;
            r_busy     <= 1'b1;
            r_code     <= w_code;
            r_saved_pc <= w_sel_halt ? pc : next_pc;
          end
        end
        ST_TAKE: begin
          r_state <= ST_SERVICE;
        end
        ST_SERVICE: begin
          if (int_ret) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign int_take   = r_take;
  assign int_vector = VECTOR;
  assign int_code   = r_code;
  assign saved_pc   = r_saved_pc;
  assign pending    = r_pending;
  assign busy       = r_busy;

endmodule

// File: tb/tb_int_controller.sv
// Self-checking bench for int_controller with a scoreboard of expected takes.
module tb_int_controller;

  localparam int NUM_SRC = 4;
  localparam int PC_W    = 11;
  localparam int TIME_W  = 16;
  localparam int CODE_W  = 32;
  localparam int PW      = NUM_SRC + 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               halt = 1'b0;
  logic               set = 1'b0;
  logic [TIME_W-1:0]  int_time = '0;
  logic               auto_reload = 1'b0;
  logic [NUM_SRC-1:0] src_req = '0;
  logic               mask_we = 1'b0;
  logic [PW-1:0]      mask_in = '1;
  logic [PC_W-1:0]    pc = '0;
  logic [PC_W-1:0]    next_pc = '0;
  logic               get_int = 1'b0;
  logic               int_ret = 1'b0;
  logic               int_take;
  logic [PC_W-1:0]    int_vector;
  logic [CODE_W-1:0]  int_code;
  logic [PC_W-1:0]    saved_pc;
  logic [PW-1:0]      pending;
  logic               busy;

  typedef struct {
    logic [CODE_W-1:0] code;
    logic [PC_W-1:0]   spc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   takes_seen = 0;
  int   cyc = 0;

  int_controller #(
    .NUM_SRC (NUM_SRC),
    .PC_W    (PC_W),
    .TIME_W  (TIME_W),
    .CODE_W  (CODE_W),
    .VECTOR  (11'h000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .halt        (halt),
    .set         (set),
    .int_time    (int_time),
    .auto_reload (auto_reload),
    .src_req     (src_req),
    .mask_we     (mask_we),
    .mask_in     (mask_in),
    .pc          (pc),
    .next_pc     (next_pc),
    .get_int     (get_int),
    .int_ret     (int_ret),
    .int_take    (int_take),
    .int_vector  (int_vector),
    .int_code    (int_code),
    .saved_pc    (saved_pc),
    .pending     (pending),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int code, input logic [PC_W-1:0] spc);
    exp_t e;
    e.code = CODE_W'(code);
    e.spc  = spc;
    sb.push_back(e);
  endtask

  // Ticks until int_take is seen; n = ticks taken, 99 when the bound expires
  task automatic wait_take(output int n);
    n = 99;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (int_take) begin
        n = k;
        break;
      end
    end
  endtask

  // Scoreboard: every take pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && int_take) begin
      takes_seen++;
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("take_code", 64'(int_code), 64'(e.code));
        chk("take_spc", 64'(saved_pc), 64'(e.spc));
      end
    end
  end

  initial begin
    int n;
    int base;
    int t0, t1, t2;

    // Reset state
    tick(); tick();
    chk("rst_take", 64'(int_take), 64'd0);
    chk("rst_code", 64'(int_code), 64'd0);
    chk("rst_spc", 64'(saved_pc), 64'd0);
    chk("rst_pend", 64'(pending), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("vector", 64'(int_vector), 64'd0);
    rst_n = 1'b1;
    tick();

    // One-shot timer of 5
    pc = 11'h010; next_pc = 11'h014;
    push(1, 11'h014);
    set = 1'b1; int_time = 16'd5; auto_reload = 1'b0;
    tick();
    set = 1'b0;
    wait_take(n);
    chk("oneshot_lat", 64'(n), 64'd6);
    tick();
    chk("svc_busy", 64'(busy), 64'd1);
    chk("svc_code", 64'(int_code), 64'd1);
    get_int = 1'b1;
    tick();
    get_int = 1'b0;
    chk("getint_clr", 64'(int_code), 64'd0);
    chk("spc_hold", 64'(saved_pc), 64'h014);
    int_ret = 1'b1;
    tick();
    int_ret = 1'b0;
    chk("ret_busy", 64'(busy), 64'd0);
    base = takes_seen;
    repeat (12) tick();
    chk("oneshot_once", 64'(takes_seen), 64'(base));

    // Periodic timer of 3 with prompt return
    pc = 11'h03c; next_pc = 11'h040;
    set = 1'b1; int_time = 16'd3; auto_reload = 1'b1;
    tick();
    set = 1'b0;
    t0 = 0; t1 = 0; t2 = 0;
    for (int k = 0; k < 3; k++) begin
      push(1, 11'h040);
      wait_take(n);
      if (k == 0) chk("periodic_lat", 64'(n), 64'd4);
      if (k == 0) t0 = cyc;
      if (k == 1) t1 = cyc;
      if (k == 2) t2 = cyc;
      if (k == 2) begin
        set = 1'b1; int_time = 16'd0;
      end
      tick();
      set = 1'b0;
      int_ret = 1'b1;
      tick();
      int_ret = 1'b0;
    end
    chk("period1", 64'(t1 - t0), 64'd3);
    chk("period2", 64'(t2 - t1), 64'd3);
    base = takes_seen;
    repeat (12) tick();
    chk("disarm_none", 64'(takes_seen), 64'(base));
    chk("disarm_pend", 64'(pending), 64'd0);

    // Reload in the expiry cycle discards that expiry
    pc = 11'h050; next_pc = 11'h054;
    set = 1'b1; int_time = 16'd2; auto_reload = 1'b0;
    tick();
    set = 1'b0;
    tick();
    set = 1'b1; int_time = 16'd4;
    tick();
    set = 1'b0;
    chk("loadwin_pend", 64'(pending), 64'd0);
    push(1, 11'h054);
    wait_take(n);
    chk("loadwin_lat", 64'(n), 64'd5);
    tick();
    int_ret = 1'b1;
    tick();
    int_ret = 1'b0;

    // Halt and src_req[0] together: halt first, external after return
    pc = 11'h200; next_pc = 11'h204;
    push(2, 11'h200);
    push(3, 11'h204);
    halt = 1'b1; src_req = 4'b0001;
    tick();
    halt = 1'b0;
    chk("both_pend", 64'(pending), 64'h06);
    wait_take(n);
    chk("halt_lat", 64'(n), 64'd1);
    chk("left_pend", 64'(pending), 64'h04);
    tick();
    int_ret = 1'b1;
    tick();
    int_ret = 1'b0;
    wait_take(n);
    chk("ext_after_ret", 64'(n), 64'd1);
    tick();
    int_ret = 1'b1;
    tick();
    int_ret = 1'b0;
    src_req = 4'b0000;
    tick();

    // Masked source latches, unmasking triggers take
    pc = 11'h300; next_pc = 11'h304;
    mask_in = 6'b111011; mask_we = 1'b1;
    tick();
    mask_we = 1'b0;
    src_req = 4'b0001;
    tick();
    chk("mask_pend", 64'(pending), 64'h04);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mask_hold", 64'(int_take), 64'd0);
    end
    push(3, 11'h304);
    mask_in = 6'b111111; mask_we = 1'b1;
    wait_take(n);
    mask_we = 1'b0;
    chk("unmask_lat", 64'(n), 64'd2);
    tick();
    get_int = 1'b1; src_req = 4'b0011;
    tick();
    get_int = 1'b0;
    chk("getint_edge_code", 64'(int_code), 64'd0);
    chk("getint_edge_pend", 64'(pending), 64'h08);
    chk("nest_busy", 64'(busy), 64'd1);
    push(4, 11'h304);
    int_ret = 1'b1;
    tick();
    int_ret = 1'b0;
    wait_take(n);
    chk("src1_lat", 64'(n), 64'd1);
    tick();
    int_ret = 1'b1;
    tick();
    int_ret = 1'b0;
    src_req = 4'b0000;
    tick();

    // Reset during service with an armed periodic timer
    pc = 11'h400; next_pc = 11'h404;
    set = 1'b1; int_time = 16'd20; auto_reload = 1'b1;
    tick();
    set = 1'b0;
    halt = 1'b1;
    tick();
    halt = 1'b0;
    push(2, 11'h400);
    wait_take(n);
    chk("pre_rst_lat", 64'(n), 64'd1);
    tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_code", 64'(int_code), 64'd0);
    chk("arst_spc", 64'(saved_pc), 64'd0);
    chk("arst_take", 64'(int_take), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    base = takes_seen;
    repeat (40) tick();
    chk("post_rst_none", 64'(takes_seen), 64'(base));
    chk("post_rst_pend", 64'(pending), 64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
